// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered LSU results onto the register file write port, with kill and forwarding
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_alu_valid,
  input  logic [AW-1:0]          i_alu_rd,
  input  logic [DW-1:0]          i_alu_data,
  input  logic                   i_lsu_valid,
  output logic                   o_lsu_ready,
  input  logic [AW-1:0]          i_lsu_rd,
  input  logic [DW-1:0]          i_lsu_data,
  output logic [AW-1:0]          o_wr_addr,
  output logic [DW-1:0]          o_wr_data,
  output logic                   o_wr_wren,
  input  logic [AW-1:0]          i_rs1_addr,
  input  logic [AW-1:0]          i_rs2_addr,
  output logic                   o_rs1_fwd_hit,
  output logic                   o_rs2_fwd_hit,
  output logic [DW-1:0]          o_rs1_fwd_data,
  output logic [DW-1:0]          o_rs2_fwd_data,
  output logic [$clog2(DEPTH):0] o_pending
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] rd_q [DEPTH];
  logic [AW-1:0] rd_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0] count_q, count_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic wr_wren_q, wr_wren_d, alu_win, push, pop, live;
  assign o_lsu_ready = count_q < (PW+1)'(DEPTH);
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_wr_wren = wr_wren_q;
  // arbitration: ALU wins the output stage, otherwise the FIFO head drains; ALU writes kill older same-rd entries
  always_comb begin
    alu_win = i_alu_valid && i_alu_rd != '0;
    push = i_lsu_valid && o_lsu_ready && i_lsu_rd != '0;
    pop = !alu_win && count_q != '0;
    rd_d = rd_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) kill_d[i] = kill_q[i] || (alu_win && rd_q[i] == i_alu_rd);
    if (push) begin
      rd_d[tail_q] = i_lsu_rd;
      data_d[tail_q] = i_lsu_data;
      kill_d[tail_q] = 1'b0;
    end
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_wren_d = alu_win || (pop && !kill_q[head_q]);
    wr_addr_d = alu_win ? i_alu_rd : pop ? rd_q[head_q] : wr_addr_q;
    wr_data_d = alu_win ? i_alu_data : pop ? data_q[head_q] : wr_data_q;
  end
  // live-entry count and forwarding: output stage is oldest, later live FIFO entries override it
  always_comb begin
    idx = '0;
    live = 1'b0;
    o_pending = '0;
    o_rs1_fwd_hit = wr_wren_q && i_rs1_addr != '0 && wr_addr_q == i_rs1_addr;
    o_rs2_fwd_hit = wr_wren_q && i_rs2_addr != '0 && wr_addr_q == i_rs2_addr;
    o_rs1_fwd_data = o_rs1_fwd_hit ? wr_data_q : '0;
    o_rs2_fwd_data = o_rs2_fwd_hit ? wr_data_q : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      live = (PW+1)'(i) < count_q && !kill_q[idx];
      o_pending = o_pending + (PW+1)'(live);
      if (live && i_rs1_addr != '0 && rd_q[idx] == i_rs1_addr) begin
        o_rs1_fwd_hit = 1'b1;
        o_rs1_fwd_data = data_q[idx];
      end
      if (live && i_rs2_addr != '0 && rd_q[idx] == i_rs2_addr) begin
        o_rs2_fwd_hit = 1'b1;
        o_rs2_fwd_data = data_q[idx];
      end
    end
  end
  // state registers; reset discards all buffered writes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        data_q[i] <= '0;
      end
      kill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_wren_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      data_q <= data_d;
      kill_q <= kill_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_wren_q <= wr_wren_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with a queue-based reference model and per-cycle compare
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_alu_valid = 1'b0;
  logic [AW-1:0] i_alu_rd = '0;
  logic [DW-1:0] i_alu_data = '0;
  logic i_lsu_valid = 1'b0;
  logic [AW-1:0] i_lsu_rd = '0;
  logic [DW-1:0] i_lsu_data = '0;
  logic [AW-1:0] i_rs1_addr = '0;
  logic [AW-1:0] i_rs2_addr = '0;
  logic o_lsu_ready, o_wr_wren, o_rs1_fwd_hit, o_rs2_fwd_hit;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data, o_rs1_fwd_data, o_rs2_fwd_data;
  logic [2:0] o_pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_wren(o_wr_wren),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_fwd_hit(o_rs1_fwd_hit), .o_rs2_fwd_hit(o_rs2_fwd_hit),
    .o_rs1_fwd_data(o_rs1_fwd_data), .o_rs2_fwd_data(o_rs2_fwd_data),
    .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    bit k;
  } ent_t;

  ent_t q[$];
  bit m_wren = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] dut_rf [32];
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_step();
    bit alu, push;
    ent_t e;
    alu = i_alu_valid && i_alu_rd != 0;
    push = i_lsu_valid && q.size() < DEPTH && i_lsu_rd != 0;
    if (alu) begin
      foreach (q[i]) if (q[i].rd == i_alu_rd) q[i].k = 1'b1;
      m_wren = 1'b1;
      m_addr = i_alu_rd;
      m_data = i_alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_wren = !e.k;
      m_addr = e.rd;
      m_data = e.d;
    end else m_wren = 1'b0;
    if (push) begin
      e.rd = i_lsu_rd;
      e.d = i_lsu_data;
      e.k = 1'b0;
      q.push_back(e);
    end
  endtask

  function automatic void fwd(input logic [AW-1:0] a, output bit h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a == 0) return;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!q[i].k && q[i].rd == a) begin
        h = 1'b1;
        d = q[i].d;
        return;
      end
    if (m_wren && m_addr == a) begin
      h = 1'b1;
      d = m_data;
    end
  endfunction

  task automatic compare();
    int pend;
    bit h1, h2;
    logic [DW-1:0] d1, d2;
    pend = 0;
    foreach (q[i]) if (!q[i].k) pend++;
    fwd(i_rs1_addr, h1, d1);
    fwd(i_rs2_addr, h2, d2);
    check("wren", DW'(o_wr_wren), DW'(m_wren));
    if (m_wren) begin
      check("wr_addr", DW'(o_wr_addr), DW'(m_addr));
      check("wr_data", o_wr_data, m_data);
    end
    check("lsu_ready", DW'(o_lsu_ready), DW'(q.size() < DEPTH));
    check("pending", DW'(o_pending), DW'(pend));
    check("rs1_hit", DW'(o_rs1_fwd_hit), DW'(h1));
    check("rs2_hit", DW'(o_rs2_fwd_hit), DW'(h2));
    check("rs1_data", o_rs1_fwd_data, d1);
    check("rs2_data", o_rs2_fwd_data, d2);
  endtask

  initial forever begin
    @(posedge i_clk);
    if (i_rst) model_step();
    else model_reset();
  end

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst && o_wr_wren) dut_rf[o_wr_addr] = o_wr_data;
      if (chk_en && i_rst) compare();
    end
  end

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
    #2;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_wren"}, DW'(o_wr_wren), 0);
    check({tag, "_addr"}, DW'(o_wr_addr), 0);
    check({tag, "_data"}, o_wr_data, 0);
    check({tag, "_pending"}, DW'(o_pending), 0);
    check({tag, "_ready"}, DW'(o_lsu_ready), 1);
    check({tag, "_hit1"}, DW'(o_rs1_fwd_hit), 0);
    check({tag, "_hit2"}, DW'(o_rs2_fwd_hit), 0);
  endtask

  initial begin
    int pushed;
    #3;
    reset_outputs_zero("por");
    step();
    step();
    i_rst = 1'b1;
    chk_en = 1'b1;
    step();
    check("post_rst_wren", DW'(o_wr_wren), 0);

    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'd30;
    step();
    check("alu3_wren", DW'(o_wr_wren), 1);
    check("alu3_addr", DW'(o_wr_addr), 3);
    check("alu3_data", o_wr_data, 30);
    i_alu_valid = 1'b0;
    step();
    check("alu3_once", DW'(o_wr_wren), 0);
    check("x3", dut_rf[3], 30);

    pushed = 0;
    for (int t = 0; t < 20 && pushed < 4; t++) begin
      i_alu_valid = 1'b1; i_alu_rd = AW'(1 + t % 5); i_alu_data = DW'(100 + t);
      i_lsu_valid = 1'b1; i_lsu_rd = AW'(10 + pushed); i_lsu_data = DW'(32'hA0 + pushed);
      if (o_lsu_ready) begin
        step();
        pushed++;
      end else step();
    end
    check("push_count", DW'(pushed), 4);
    i_alu_rd = 5'd2; i_lsu_rd = 5'd14; i_lsu_data = 32'hA4;
    check("full_ready", DW'(o_lsu_ready), 0);
    check("full_pending", DW'(o_pending), 4);
    step();
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain_wren", DW'(o_wr_wren), 1);
      check("drain_addr", DW'(o_wr_addr), DW'(10 + k));
      check("drain_data", o_wr_data, DW'(32'hA0 + k));
    end
    step();
    check("drain_idle", DW'(o_wr_wren), 0);
    check("drain_pending", DW'(o_pending), 0);

    i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'd1;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_data = 32'h1111;
    i_rs1_addr = 5'd7;
    step();
    check("kill_pre_pending", DW'(o_pending), 1);
    check("kill_pre_fwd", o_rs1_fwd_data, 32'h1111);
    i_lsu_valid = 1'b0; i_alu_rd = 5'd7; i_alu_data = 32'h2222;
    step();
    check("kill_pending", DW'(o_pending), 0);
    check("kill_alu_data", o_wr_data, 32'h2222);
    i_alu_valid = 1'b0;
    step();
    check("killed_pop_wren", DW'(o_wr_wren), 0);
    step();
    check("x7", dut_rf[7], 32'h2222);
    i_rs1_addr = 5'd0;

    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hDEAD;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'hBEEF;
    step();
    check("rd0_wren", DW'(o_wr_wren), 0);
    check("rd0_pending", DW'(o_pending), 0);
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    step();
    check("rd0_wren2", DW'(o_wr_wren), 0);
    check("rd0_pending2", DW'(o_pending), 0);
    check("x0", dut_rf[0], 0);

    i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'd11;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd5; i_lsu_data = 32'h55;
    step();
    i_alu_rd = 5'd2; i_lsu_data = 32'h66;
    step();
    i_lsu_valid = 1'b0;
    i_rs1_addr = 5'd5; i_rs2_addr = 5'd5;
    #1;
    check("fwd_rs1_hit", DW'(o_rs1_fwd_hit), 1);
    check("fwd_rs1_data", o_rs1_fwd_data, 32'h66);
    check("fwd_rs2_hit", DW'(o_rs2_fwd_hit), 1);
    check("fwd_rs2_data", o_rs2_fwd_data, 32'h66);
    i_rs1_addr = 5'd0;
    #1;
    check("fwd_x0_hit", DW'(o_rs1_fwd_hit), 0);
    check("fwd_x0_data", o_rs1_fwd_data, 0);
    i_alu_valid = 1'b0;
    step();
    step();
    step();
    check("x5", dut_rf[5], 32'h66);
    i_rs2_addr = 5'd0;

    i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'd12;
    for (int k = 0; k < 4; k++) begin
      i_lsu_valid = 1'b1; i_lsu_rd = AW'(20 + k); i_lsu_data = DW'(32'hC0 + k);
      step();
    end
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    step();
    check("mid_pending", DW'(o_pending), 3);
    #1;
    chk_en = 1'b0;
    i_rst = 1'b0;
    #1;
    reset_outputs_zero("async");
    @(posedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rel_pending", DW'(o_pending), 0);
    check("rel_ready", DW'(o_lsu_ready), 1);
    check("rel_wren", DW'(o_wr_wren), 0);
    step();
    check("rel_wren2", DW'(o_wr_wren), 0);
    step();
    step();
    check("x21", dut_rf[21], 0);
    check("x22", dut_rf[22], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
